// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA types and 640x480 mode constants
// Contents:
//   t_lock_state  - lock tracker states for the timing receiver
//   t_timing_meas - one frame's worth of timing measurements
//   c_640_*       - 640x480@60 mode constants, shared with the generator
package vga_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    CHECKING = 2'd1,
    LOCKED   = 2'd2
  } t_lock_state;

  // Fields are wide enough for any supported counter width; narrower
  // measurements are zero-extended into them before comparison.
  localparam int c_meas_width = 32;

  typedef struct packed {
    logic [c_meas_width-1:0] h_total;
    logic [c_meas_width-1:0] v_total;
    logic [c_meas_width-1:0] h_active;
    logic [c_meas_width-1:0] v_active;
  } t_timing_meas;

  localparam int c_640_pixel_width  = 640;
  localparam int c_640_pixel_height = 480;
  localparam int c_640_h_front      = 16;
  localparam int c_640_h_sync       = 96;
  localparam int c_640_h_back       = 48;
  localparam int c_640_v_front      = 10;
  localparam int c_640_v_sync       = 2;
  localparam int c_640_v_back       = 33;
  localparam int c_640_h_total      = 800;
  localparam int c_640_v_total      = 525;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - input register, polarity normalise and edge detect
// Ports:
//   i_clk_pixel, i_rst_n - pixel clock, asynchronous active-low reset
//   i_raw                - raw input, asserted level given by p_polarity
//   o_level              - registered input, normalised to active-high
//   o_lead               - asserted now, not asserted the cycle before
//   o_trail              - not asserted now, asserted the cycle before
module sync_edge_det #(
  parameter logic p_polarity = 1'b1
) (
  input  logic i_clk_pixel,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_lead,
  output logic o_trail
);

  logic s1_q;
  logic prev_q;

  // s1 resets to the deasserted level so an active-low input does not
  // look asserted straight out of reset and fake a leading edge.
  always_ff @(posedge i_clk_pixel or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_q   <= ~p_polarity;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= i_raw;
      prev_q <= o_level;
    end
  end

  assign o_level = s1_q ~^ p_polarity;
  assign o_lead  = o_level & ~prev_q;
  assign o_trail = ~o_level & prev_q;

endmodule

// File: rtl/vga_timing_rx.sv
// rtl/vga_timing_rx.sv - VGA timing receiver: coordinates, strobes, measurement, lock
// Ports:
//   i_clk_pixel, i_rst_n        - pixel clock, asynchronous active-low reset
//   i_hsync, i_vsync, i_data_en - raw video timing from the source
//   i_clear_err                 - pulse to clear o_timing_err
//   o_data_en, o_x_pos, o_y_pos - pixel flag and coordinates, 2 cycles after input
//   o_frame, o_line             - vsync leading edge / data_en rising edge strobes
//   o_h_total, o_v_total        - measured clocks per line / lines per frame
//   o_h_active, o_v_active      - measured active pixels per line / active lines
//   o_locked, o_timing_err      - lock status, sticky loss-of-lock flag
module vga_timing_rx
  import vga_pkg::*;
#(
  parameter int   p_pixel_width    = c_640_pixel_width,
  parameter int   p_pixel_height   = c_640_pixel_height,
  parameter int   p_h_total        = c_640_h_total,
  parameter int   p_v_total        = c_640_v_total,
  parameter logic p_hsync_polarity = 1'b1,
  parameter logic p_vsync_polarity = 1'b1,
  parameter int   p_lock_frames    = 2,
  parameter int   p_count_width    = 16
) (
  input  logic                     i_clk_pixel,
  input  logic                     i_rst_n,
  input  logic                     i_hsync,
  input  logic                     i_vsync,
  input  logic                     i_data_en,
  input  logic                     i_clear_err,
  output logic                     o_data_en,
  output logic [p_count_width-1:0] o_x_pos,
  output logic [p_count_width-1:0] o_y_pos,
  output logic                     o_frame,
  output logic                     o_line,
  output logic [p_count_width-1:0] o_h_total,
  output logic [p_count_width-1:0] o_v_total,
  output logic [p_count_width-1:0] o_h_active,
  output logic [p_count_width-1:0] o_v_active,
  output logic                     o_locked,
  output logic                     o_timing_err
);

  localparam logic [p_count_width-1:0] c_one         = p_count_width'(1);
  localparam logic [p_count_width-1:0] c_lock_target = p_count_width'(p_lock_frames);

  localparam t_timing_meas c_expect = '{
    h_total:  c_meas_width'(p_h_total),
    v_total:  c_meas_width'(p_v_total),
    h_active: c_meas_width'(p_pixel_width),
    v_active: c_meas_width'(p_pixel_height)
  };

  function automatic logic [p_count_width-1:0] sat_inc(input logic [p_count_width-1:0] v);
    return (&v) ? v : v + c_one;
  endfunction

  // Input stage
  logic hs_level, hs_lead, hs_trail;
  logic vs_level, vs_lead, vs_trail;
  logic de_level, de_rise, de_fall;

  sync_edge_det #(.p_polarity(p_hsync_polarity)) u_hsync (
    .i_clk_pixel (i_clk_pixel),
    .i_rst_n     (i_rst_n),
    .i_raw       (i_hsync),
    .o_level     (hs_level),
    .o_lead      (hs_lead),
    .o_trail     (hs_trail)
  );

  sync_edge_det #(.p_polarity(p_vsync_polarity)) u_vsync (
    .i_clk_pixel (i_clk_pixel),
    .i_rst_n     (i_rst_n),
    .i_raw       (i_vsync),
    .o_level     (vs_level),
    .o_lead      (vs_lead),
    .o_trail     (vs_trail)
  );

  sync_edge_det #(.p_polarity(1'b1)) u_data_en (
    .i_clk_pixel (i_clk_pixel),
    .i_rst_n     (i_rst_n),
    .i_raw       (i_data_en),
    .o_level     (de_level),
    .o_lead      (de_rise),
    .o_trail     (de_fall)
  );

  // Sync levels and trailing edges are not needed by this block.
  logic unused_sync;
  assign unused_sync = &{1'b0, hs_level, hs_trail, vs_level, vs_trail};

  // Working registers
  logic [p_count_width-1:0] h_cnt_q, v_cnt_q, a_cnt_q, line_cnt_q;
  logic [p_count_width-1:0] x_q, y_q;
  logic                     y_pend_q;
  logic                     seen_vs_q;
  logic [p_count_width-1:0] h_total_q, v_total_q, h_active_q, v_active_q;
  logic                     de_q, frame_q, line_q, err_q;

  // Measurement values as they will be after this edge; the lock check
  // uses these so a frame is judged on the numbers latched with it.
  logic [p_count_width-1:0] h_total_d, v_total_d, h_active_d, v_active_d;
  t_timing_meas             meas_d;
  logic                     frame_match;

  always_comb begin
    h_total_d  = h_total_q;
    v_total_d  = v_total_q;
    h_active_d = h_active_q;
    v_active_d = v_active_q;
    if (hs_lead) h_total_d = h_cnt_q;
    if (vs_lead) begin
      // A coincident hsync edge belongs to the frame being closed.
      v_total_d  = hs_lead ? sat_inc(v_cnt_q) : v_cnt_q;
      v_active_d = line_cnt_q;
    end
    if (de_fall) h_active_d = a_cnt_q;

    meas_d.h_total  = c_meas_width'(h_total_d);
    meas_d.v_total  = c_meas_width'(v_total_d);
    meas_d.h_active = c_meas_width'(h_active_d);
    meas_d.v_active = c_meas_width'(v_active_d);
    // The span up to the first vsync after reset is a partial frame.
    frame_match = (meas_d == c_expect) && seen_vs_q;
  end

  always_ff @(posedge i_clk_pixel or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      a_cnt_q    <= '0;
      line_cnt_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
      y_pend_q   <= 1'b0;
      seen_vs_q  <= 1'b0;
      h_total_q  <= '0;
      v_total_q  <= '0;
      h_active_q <= '0;
      v_active_q <= '0;
      de_q       <= 1'b0;
      frame_q    <= 1'b0;
      line_q     <= 1'b0;
    end else begin
      h_total_q  <= h_total_d;
      v_total_q  <= v_total_d;
      h_active_q <= h_active_d;
      v_active_q <= v_active_d;

      h_cnt_q <= hs_lead ? c_one : sat_inc(h_cnt_q);

      if (vs_lead)      v_cnt_q <= '0;
      else if (hs_lead) v_cnt_q <= sat_inc(v_cnt_q);

      if (de_rise)       a_cnt_q <= c_one;
      else if (de_level) a_cnt_q <= sat_inc(a_cnt_q);

      if (vs_lead)      line_cnt_q <= de_rise ? c_one : '0;
      else if (de_rise) line_cnt_q <= sat_inc(line_cnt_q);

      if (de_rise)       x_q <= '0;
      else if (de_level) x_q <= sat_inc(x_q);

      // y restarts on the first active line after a vsync edge.
      if (de_rise) begin
        y_q      <= (y_pend_q || vs_lead) ? '0 : sat_inc(y_q);
        y_pend_q <= 1'b0;
      end else if (vs_lead) begin
        y_pend_q <= 1'b1;
      end

      if (vs_lead) seen_vs_q <= 1'b1;

      de_q    <= de_level;
      frame_q <= vs_lead;
      line_q  <= de_rise;
    end
  end

  // Lock tracker
  t_lock_state              state_q, state_d;
  logic [p_count_width-1:0] match_cnt_q, match_cnt_d;
  logic                     err_set;

  always_ff @(posedge i_clk_pixel or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= UNLOCKED;
      match_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      if (err_set)          err_q <= 1'b1;
      else if (i_clear_err) err_q <= 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    err_set     = 1'b0;
    if (vs_lead) begin
      case (state_q)
        UNLOCKED: begin
          if (frame_match) begin
            match_cnt_d = c_one;
            state_d     = (c_lock_target <= c_one) ? LOCKED : CHECKING;
          end
        end
        CHECKING: begin
          if (frame_match) begin
            match_cnt_d = sat_inc(match_cnt_q);
            if (sat_inc(match_cnt_q) >= c_lock_target) state_d = LOCKED;
          end else begin
            state_d     = UNLOCKED;
            match_cnt_d = '0;
          end
        end
        LOCKED: begin
          if (!frame_match) begin
            state_d     = UNLOCKED;
            match_cnt_d = '0;
            err_set     = 1'b1;
          end
        end
        default: begin
          state_d     = UNLOCKED;
          match_cnt_d = '0;
        end
      endcase
    end
  end

  assign o_data_en    = de_q;
  assign o_x_pos      = x_q;
  assign o_y_pos      = y_q;
  assign o_frame      = frame_q;
  assign o_line       = line_q;
  assign o_h_total    = h_total_q;
  assign o_v_total    = v_total_q;
  assign o_h_active   = h_active_q;
  assign o_v_active   = v_active_q;
  assign o_locked     = (state_q == LOCKED);
  assign o_timing_err = err_q;

endmodule
